// File: rtl/spi_mcp3202_scan.sv
// SPI master for the MCP3202 12-bit ADC with CH0/CH1 round-robin scanning.
// Free-run or single-shot triggering, min CS-high time, overrun flag.
module spi_mcp3202_scan #(
   parameter int unsigned SCK_DIV    = 900,
   parameter int unsigned SAMPLE_DIV = 200000,
   parameter int unsigned TCSH_MIN   = 50,
   parameter bit          SGL        = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic        trig_i,
   input  logic [1:0]  ch_mask_i,
   input  logic        miso_i,
   output logic        mosi_o,
   output logic        sck_o,
   output logic        cs_n_o,
   output logic [11:0] data_o,
   output logic        data_ch_o,
   output logic        dv_o,
   output logic        busy_o,
   output logic        ovr_o
);

   localparam int unsigned PW = $clog2(SCK_DIV);
   localparam int unsigned TW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
   localparam int unsigned CW = (TCSH_MIN > 0) ? $clog2(TCSH_MIN + 1) : 1;

   localparam logic [PW-1:0] P_LAST = PW'(SCK_DIV - 1);
   localparam logic [PW-1:0] P_HALF = PW'(SCK_DIV / 2);
   localparam logic [TW-1:0] T_LAST = TW'(SAMPLE_DIV - 1);
   localparam logic [CW-1:0] C_MIN  = CW'(TCSH_MIN);
   localparam logic [4:0]    B_LAST = 5'd16;
   localparam logic [4:0]    B_DAT0 = 5'd5;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_CSH,
      XFER,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [CW-1:0] cshi_q, cshi_d;
   logic [4:0]    bit_q, bit_d;
   logic [PW-1:0] ph_q, ph_d;
   logic [11:0]   sreg_q, sreg_d;
   logic          ch_q, ch_d;
   logic          last_q, last_d;
   logic [11:0]   data_q, data_d;
   logic          dch_q, dch_d;

   logic tick;
   logic req;
   logic cs_met;
   logic nxt_ch;

   assign tick   = en_i && (tick_q == T_LAST);
   assign req    = (trig_i | tick) & (|ch_mask_i);
   assign cs_met = (cshi_q == C_MIN);

   assign cs_n_o    = (state_q != XFER);
   assign sck_o     = (state_q == XFER) && (ph_q >= P_HALF);
   assign dv_o      = (state_q == DONE);
   assign busy_o    = (state_q != IDLE);
   assign ovr_o     = req && (state_q != IDLE);
   assign data_o    = data_q;
   assign data_ch_o = dch_q;

   // Round-robin channel pick: alternate when both enabled, else the one set.
   always_comb begin
      nxt_ch = ch_mask_i[1];
      if (ch_mask_i == 2'b11) begin
         nxt_ch = ~last_q;
      end
   end

   // Command bit on MOSI for the current bit slot of the frame.
   always_comb begin
      mosi_o = 1'b0;
      if (state_q == XFER) begin
         case (bit_q)
            5'd0:    mosi_o = 1'b1;
            5'd1:    mosi_o = SGL;
            5'd2:    mosi_o = ch_q;
            5'd3:    mosi_o = 1'b1;
            default: mosi_o = 1'b0;
         endcase
      end
   end

   // Next-state logic for the FSM, timers and the receive datapath.
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      ph_d    = ph_q;
      sreg_d  = sreg_q;
      ch_d    = ch_q;
      last_d  = last_q;
      data_d  = data_q;
      dch_d   = dch_q;

      tick_d = tick_q + TW'(1);
      if (!en_i || tick) begin
         tick_d = '0;
      end

      cshi_d = cshi_q;
      if (!cs_n_o) begin
         cshi_d = '0;
      end else if (!cs_met) begin
         cshi_d = cshi_q + CW'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (req) begin
               ch_d    = nxt_ch;
               last_d  = nxt_ch;
               bit_d   = '0;
               ph_d    = '0;
               state_d = cs_met ? XFER : WAIT_CSH;
            end
         end
         WAIT_CSH: begin
            if (cs_met) begin
               state_d = XFER;
            end
         end
         XFER: begin
            if (ph_q == P_HALF && bit_q >= B_DAT0) begin
               sreg_d = {sreg_q[10:0], miso_i};
            end
            if (ph_q == P_LAST) begin
               ph_d = '0;
               if (bit_q == B_LAST) begin
                  state_d = DONE;
                  data_d  = sreg_q;
                  dch_d   = ch_q;
               end else begin
                  bit_d = bit_q + 5'd1;
               end
            end else begin
               ph_d = ph_q + PW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         tick_q  <= '0;
         cshi_q  <= '0;
         bit_q   <= '0;
         ph_q    <= '0;
         sreg_q  <= '0;
         ch_q    <= 1'b0;
         last_q  <= 1'b1;
         data_q  <= '0;
         dch_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         cshi_q  <= cshi_d;
         bit_q   <= bit_d;
         ph_q    <= ph_d;
         sreg_q  <= sreg_d;
         ch_q    <= ch_d;
         last_q  <= last_d;
         data_q  <= data_d;
         dch_q   <= dch_d;
      end
   end

endmodule

// File: tb/tb_spi_mcp3202_scan.sv
// Bench for spi_mcp3202_scan: ADC pin model, frame monitor,
// table vectors, corner-case sequences and randomized round-robin checks.
module tb_spi_mcp3202_scan;

   localparam int SCK_DIV    = 4;
   localparam int SAMPLE_DIV = 100;
   localparam int TCSH_MIN   = 8;
   localparam int LAT        = 17 * SCK_DIV + 1;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        trig = 1'b0;
   logic [1:0]  ch_mask = 2'b00;
   logic        miso = 1'b0;
   logic        mosi, sck, cs_n, data_ch, dv, busy, ovr;
   logic [11:0] data;

   spi_mcp3202_scan #(
      .SCK_DIV(SCK_DIV), .SAMPLE_DIV(SAMPLE_DIV),
      .TCSH_MIN(TCSH_MIN), .SGL(1'b1)
   ) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .trig_i(trig),
      .ch_mask_i(ch_mask), .miso_i(miso), .mosi_o(mosi),
      .sck_o(sck), .cs_n_o(cs_n), .data_o(data),
      .data_ch_o(data_ch), .dv_o(dv), .busy_o(busy), .ovr_o(ovr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [11:0] adc_val [2];

   // monitor / ADC model state
   logic       cs_prev = 1'b1;
   logic       sck_prev = 1'b0;
   int         rise_cnt = 0;
   int         fall_cnt = 0;
   logic [3:0] cmd = 4'h0;
   int         n_frames = 0;
   int         n_dv = 0;
   int         n_ovr = 0;
   int         n_busy = 0;
   int         n_stray = 0;
   int         rise_cyc = 0;
   bit         have_rise = 1'b0;
   int         gap_last = 0;
   int         frame_rises = 0;
   logic [3:0] frame_cmd = 4'h0;
   int         dv_cyc_q[$];
   logic [11:0] dv_dat_q[$];
   logic       dv_ch_q[$];
   logic       dv_odd_q[$];

   // ADC pin model plus frame bookkeeping, sampled mid-cycle
   always @(negedge clk) begin
      if (cs_prev && !cs_n) begin
         rise_cnt <= 0;
         fall_cnt <= 0;
         cmd      <= 4'h0;
         miso     <= 1'b0;
         n_frames <= n_frames + 1;
         if (have_rise) gap_last <= cyc - rise_cyc;
      end
      if (!cs_prev && cs_n) begin
         rise_cyc    <= cyc;
         have_rise   <= 1'b1;
         frame_rises <= rise_cnt;
         frame_cmd   <= cmd;
      end
      if (!sck_prev && sck) begin
         if (cs_n) n_stray <= n_stray + 1;
         rise_cnt <= rise_cnt + 1;
         if (rise_cnt < 4) cmd <= {cmd[2:0], mosi};
      end
      if (sck_prev && !sck) begin
         fall_cnt <= fall_cnt + 1;
         if (fall_cnt >= 4 && fall_cnt <= 15)
            miso <= adc_val[cmd[1]][15-fall_cnt];
         else
            miso <= 1'b0;
      end
      if (dv) begin
         n_dv <= n_dv + 1;
         dv_cyc_q.push_back(cyc);
         dv_dat_q.push_back(data);
         dv_ch_q.push_back(data_ch);
         dv_odd_q.push_back(cmd[1]);
      end
      if (ovr) n_ovr <= n_ovr + 1;
      if (busy) n_busy <= n_busy + 1;
      cs_prev  <= cs_n;
      sck_prev <= sck;
   end

   int n_cmp = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_ge(input string name, input int act, input int lim);
      n_cmp++;
      if (act < lim) begin
         n_fail++;
         $display("FAIL %s: got %0d, required >= %0d", name, act, lim);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic pulse_trig(input logic [1:0] m, output int k);
      @(posedge clk); #1;
      trig = 1'b1;
      ch_mask = m;
      k = cyc;
      @(posedge clk); #1;
      trig = 1'b0;
   endtask

   task automatic wait_dv_count(input int target, input int budget);
      int i;
      for (i = 0; i < budget && n_dv < target; i++) @(posedge clk);
      if (n_dv < target) check("dv_wait_timeout", n_dv, target);
      #1;
   endtask

   task automatic run_frame(input logic [1:0] m, output int lat,
                            output logic [11:0] d, output logic c,
                            output int rises, output logic [3:0] cm);
      int k;
      bit got;
      pulse_trig(m, k);
      got = 1'b0;
      lat = -1;
      d = '0;
      c = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         if (dv) begin
            got = 1'b1;
            lat = cyc - k;
            d = data;
            c = data_ch;
         end else begin
            @(posedge clk); #1;
         end
      end
      if (!got) check("dv_timeout", 0, 1);
      @(negedge clk); #1;
      rises = frame_rises;
      cm = frame_cmd;
   endtask

   function automatic logic rr_pick(input logic [1:0] m, input logic last);
      int c;
      for (int i = 1; i <= 2; i++) begin
         c = (int'(last) + i) % 2;
         if (m[c]) return c[0];
      end
      return last;
   endfunction

   typedef struct {
      logic [1:0]  mask;
      logic [11:0] v0;
      logic [11:0] v1;
      logic        exp_ch;
      logic [11:0] exp_d;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int lat, rises, k, base, b_ovr, b_fr, b_dv, b_busy;
      logic [11:0] d;
      logic c, mch;
      logic [3:0] cm;

      tbl[0] = '{2'b01, 12'hA5C, 12'h000, 1'b0, 12'hA5C};
      tbl[1] = '{2'b11, 12'h123, 12'hFED, 1'b1, 12'hFED};
      tbl[2] = '{2'b11, 12'h123, 12'hFED, 1'b0, 12'h123};
      tbl[3] = '{2'b10, 12'h555, 12'h800, 1'b1, 12'h800};
      tbl[4] = '{2'b10, 12'h555, 12'h001, 1'b1, 12'h001};
      tbl[5] = '{2'b11, 12'hFFF, 12'h0F0, 1'b0, 12'hFFF};
      tbl[6] = '{2'b01, 12'h000, 12'hAAA, 1'b0, 12'h000};
      tbl[7] = '{2'b11, 12'h3C3, 12'h7FF, 1'b1, 12'h7FF};
      adc_val[0] = '0;
      adc_val[1] = '0;

      do_reset();
      check("rst_cs_n", cs_n, 1);
      check("rst_sck", sck, 0);
      check("rst_mosi", mosi, 0);
      check("rst_data", data, 0);
      check("rst_data_ch", data_ch, 0);
      check("rst_dv", dv, 0);
      check("rst_busy", busy, 0);
      check("rst_ovr", ovr, 0);
      idle(20);

      foreach (tbl[i]) begin
         adc_val[0] = tbl[i].v0;
         adc_val[1] = tbl[i].v1;
         run_frame(tbl[i].mask, lat, d, c, rises, cm);
         check($sformatf("vec%0d_data", i), d, tbl[i].exp_d);
         check($sformatf("vec%0d_ch", i), c, tbl[i].exp_ch);
         check($sformatf("vec%0d_lat", i), lat, LAT);
         check($sformatf("vec%0d_sck", i), rises, 17);
         check($sformatf("vec%0d_cmd", i), cm, {3'b110, tbl[i].exp_ch} << 0 == 0 ? 0 : {2'b11, tbl[i].exp_ch, 1'b1});
         idle(12);
      end

      // free-run scan over both channels
      do_reset();
      idle(20);
      adc_val[0] = 12'h123;
      adc_val[1] = 12'hFED;
      base = dv_cyc_q.size();
      @(posedge clk); #1;
      ch_mask = 2'b11;
      en = 1'b1;
      for (int i = 0; i < 600 && dv_cyc_q.size() < base + 4; i++)
         @(posedge clk);
      #1;
      en = 1'b0;
      if (dv_cyc_q.size() < base + 4) begin
         check("frun_dv_count", dv_cyc_q.size() - base, 4);
      end else begin
         for (int i = 0; i < 4; i++) begin
            check($sformatf("frun%0d_ch", i), dv_ch_q[base+i], i % 2);
            check($sformatf("frun%0d_data", i), dv_dat_q[base+i],
                  (i % 2) ? 12'hFED : 12'h123);
            check($sformatf("frun%0d_odd", i), dv_odd_q[base+i],
                  dv_ch_q[base+i]);
            if (i > 0)
               check($sformatf("frun%0d_period", i),
                     dv_cyc_q[base+i] - dv_cyc_q[base+i-1], SAMPLE_DIV);
         end
      end
      idle(120);

      // trig while a frame is in flight
      adc_val[0] = 12'h3C5;
      b_ovr = n_ovr;
      b_fr = n_frames;
      b_dv = n_dv;
      pulse_trig(2'b01, k);
      idle(20);
      pulse_trig(2'b01, k);
      wait_dv_count(b_dv + 1, 200);
      check("ovr_data", data, 12'h3C5);
      idle(150);
      check("ovr_pulses", n_ovr - b_ovr, 1);
      check("ovr_frames", n_frames - b_fr, 1);
      check("ovr_dvs", n_dv - b_dv, 1);

      // two triggers 70 cycles apart
      b_ovr = n_ovr;
      b_fr = n_frames;
      b_dv = n_dv;
      pulse_trig(2'b01, k);
      repeat (69) @(posedge clk);
      #1;
      trig = 1'b1;
      @(posedge clk); #1;
      trig = 1'b0;
      wait_dv_count(b_dv + 2, 300);
      check("b2b_frames", n_frames - b_fr, 2);
      check("b2b_no_ovr", n_ovr - b_ovr, 0);
      check_ge("b2b_cs_high", gap_last, TCSH_MIN);
      idle(20);

      // reset in the middle of a frame
      adc_val[0] = 12'h9A6;
      adc_val[1] = 12'h456;
      pulse_trig(2'b01, k);
      for (int i = 0; i < 200 && rise_cnt < 10; i++) begin
         @(posedge clk); #1;
      end
      check("mid_reached_bit10", rise_cnt >= 10, 1);
      b_dv = n_dv;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_cs_n", cs_n, 1);
      check("mid_sck", sck, 0);
      check("mid_dv", dv, 0);
      check("mid_data", data, 0);
      check("mid_busy", busy, 0);
      idle(100);
      check("mid_no_dv", n_dv - b_dv, 0);
      run_frame(2'b11, lat, d, c, rises, cm);
      check("post_rst_ch", c, 0);
      check("post_rst_data", d, 12'h9A6);
      check("post_rst_lat", lat, LAT);
      idle(20);

      // empty mask: requests ignored
      b_ovr = n_ovr;
      b_fr = n_frames;
      b_dv = n_dv;
      b_busy = n_busy;
      @(posedge clk); #1;
      ch_mask = 2'b00;
      en = 1'b1;
      idle(100);
      pulse_trig(2'b00, k);
      idle(400);
      #1;
      en = 1'b0;
      check("m0_frames", n_frames - b_fr, 0);
      check("m0_dv", n_dv - b_dv, 0);
      check("m0_ovr", n_ovr - b_ovr, 0);
      check("m0_busy", n_busy - b_busy, 0);

      // randomized single shots against round-robin model
      do_reset();
      mch = 1'b1;
      idle(20);
      for (int i = 0; i < 12; i++) begin
         logic [1:0] m;
         logic ech;
         m = 2'($urandom_range(1, 3));
         adc_val[0] = 12'($urandom);
         adc_val[1] = 12'($urandom);
         ech = rr_pick(m, mch);
         mch = ech;
         run_frame(m, lat, d, c, rises, cm);
         check($sformatf("rnd%0d_ch", i), c, ech);
         check($sformatf("rnd%0d_data", i), d, adc_val[ech]);
         check($sformatf("rnd%0d_lat", i), lat, LAT);
         check($sformatf("rnd%0d_odd", i), cm[1], ech);
         idle($urandom_range(10, 40));
      end

      check("stray_sck", n_stray, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
